// File: rtl/sccb_cfg_sequencer.sv
// Walks a {reg_addr, reg_val} table and pushes each entry to an SCCB write core.
// Supports delay entries, a terminator, per-entry retries and a response timeout.
module sccb_cfg_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int GAP_CYCLES     = 100,
    parameter int DELAY_CYCLES   = 250000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int RETRY_MAX      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_reg_addr,
    output logic [7:0]        sccb_reg_data,
    input  logic              sccb_ack,
    input  logic              sccb_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] fail_index,
    output logic [2:0]        state_dbg
);
    localparam int WAIT_MAX = (DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES;
    localparam int WAIT_W   = ($clog2(WAIT_MAX + 1) < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam int TMO_W    = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int RETRY_W  = ($clog2(RETRY_MAX + 1) < 1) ? 1 : $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT_ACK, S_GAP, S_DELAY, S_DONE, S_ERROR
    } state_t;

    // Handshake: sccb_req is a single-cycle pulse while in ISSUE; the core answers
    // with a single-cycle sccb_ack or sccb_nack, which only counts during WAIT_ACK.
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                retry_pend_q, retry_pend_d;
    logic                req_q, req_d;
    logic [7:0]          reg_addr_q, reg_addr_d;
    logic [7:0]          reg_data_q, reg_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   fail_index_q, fail_index_d;

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        wait_d       = wait_q;
        tmo_d        = tmo_q;
        retry_d      = retry_q;
        retry_pend_d = retry_pend_q;
        req_d        = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_data_d   = reg_data_q;
        done_d       = done_q;
        error_d      = error_q;
        fail_index_d = fail_index_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    index_d      = '0;
                    retry_d      = '0;
                    retry_pend_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rom_data == 16'hFFFF) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rom_data == 16'hFFF0) begin
                    wait_d  = WAIT_W'(DELAY_CYCLES);
                    state_d = S_DELAY;
                end else begin
                    reg_addr_d = rom_data[15:8];
                    reg_data_d = rom_data[7:0];
                    req_d      = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                tmo_d = tmo_q + 1'b1;
                // A simultaneous ack+nack is a failure; ack on the timeout cycle still wins.
                if (sccb_nack || (!sccb_ack && (tmo_d == TMO_W'(TIMEOUT_CYCLES)))) begin
                    if (retry_q < RETRY_W'(RETRY_MAX)) begin
                        retry_d      = retry_q + 1'b1;
                        retry_pend_d = 1'b1;
                        wait_d       = WAIT_W'(GAP_CYCLES);
                        state_d      = S_GAP;
                    end else begin
                        error_d      = 1'b1;
                        fail_index_d = index_q;
                        state_d      = S_ERROR;
                    end
                end else if (sccb_ack) begin
                    retry_d = '0;
                    if (index_q == '1) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        index_d      = index_q + 1'b1;
                        retry_pend_d = 1'b0;
                        wait_d       = WAIT_W'(GAP_CYCLES);
                        state_d      = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (wait_q <= WAIT_W'(1)) begin
                    if (retry_pend_q) begin
                        req_d   = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_DELAY: begin
                if (wait_q <= WAIT_W'(1)) begin
                    index_d = index_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            wait_q       <= '0;
            tmo_q        <= '0;
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
            req_q        <= 1'b0;
            reg_addr_q   <= '0;
            reg_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            fail_index_q <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            wait_q       <= wait_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            retry_pend_q <= retry_pend_d;
            req_q        <= req_d;
            reg_addr_q   <= reg_addr_d;
            reg_data_q   <= reg_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            fail_index_q <= fail_index_d;
        end
    end

    assign rom_addr      = index_q;
    assign sccb_req      = req_q;
    assign sccb_reg_addr = reg_addr_q;
    assign sccb_reg_data = reg_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign fail_index    = fail_index_q;
    assign state_dbg     = state_q;
endmodule
